// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the 16-bit CPU control path.
//   - OP_*      : instruction opcodes held in ir[15:12]
//   - BUS_*     : shared-bus source select codes
//   - seq_state_e : sequencer FSM state encoding
//   - bus_reg() : bus_sel code for general register rN
package cpu_pkg;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_JMP  = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd5;

  localparam logic [3:0] BUS_R0   = 4'd0;
  localparam logic [3:0] BUS_R1   = 4'd1;
  localparam logic [3:0] BUS_R2   = 4'd2;
  localparam logic [3:0] BUS_R3   = 4'd3;
  localparam logic [3:0] BUS_R4   = 4'd4;
  localparam logic [3:0] BUS_R5   = 4'd5;
  localparam logic [3:0] BUS_R6   = 4'd6;
  localparam logic [3:0] BUS_R7   = 4'd7;
  localparam logic [3:0] BUS_G    = 4'd8;
  localparam logic [3:0] BUS_MEM  = 4'd9;
  localparam logic [3:0] BUS_NONE = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StEx1,
    StEx2,
    StEx3,
    StHalt
  } seq_state_e;

  // Register codes occupy the low half of the bus_sel space.
  function automatic logic [3:0] bus_reg(input logic [2:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control bundle between the sequencer and the datapath/memory.
//   run       : start/continue execution request
//   mem_data  : instruction memory word at the current PC (combinational)
//   pc_enable, pc_select : PC update strobe and source (0 = PC+1, 1 = bus)
//   bus_sel   : shared-bus source (0-7 regs, 8 G, 9 mem_data, 15 none)
//   reg_we    : one-hot register write enable
//   a_load, g_load, alu_sub : ALU latch enables and operation
//   busy, halted : sequencer status
// modport master = sequencer side, slave = datapath/environment side.
interface cpu_sequencer_if #(
  parameter int unsigned NREG = 8,
  parameter int unsigned W    = 16
);

  logic            run;
  logic [W-1:0]    mem_data;
  logic            pc_enable;
  logic            pc_select;
  logic [3:0]      bus_sel;
  logic [NREG-1:0] reg_we;
  logic            a_load;
  logic            g_load;
  logic            alu_sub;
  logic            busy;
  logic            halted;

  modport master (
    input  run, mem_data,
    output pc_enable, pc_select, bus_sel, reg_we, a_load, g_load, alu_sub, busy, halted
  );

  modport slave (
    output run, mem_data,
    input  pc_enable, pc_select, bus_sel, reg_we, a_load, g_load, alu_sub, busy, halted
  );

endinterface

// File: rtl/cpu_ir_decode.sv
// cpu_ir_decode: combinational strobe decoder for the sequencer.
//   state, op, rx, ry : current FSM state and IR fields
//   pc_enable .. halted : datapath strobes for this cycle
//   final_cycle : high on the last execute cycle of the current instruction
//                 (HALT's EX1 included; the caller routes it to StHalt)
module cpu_ir_decode
  import cpu_pkg::*;
#(
  parameter int unsigned NREG = 8
) (
  input  seq_state_e      state,
  input  logic [3:0]      op,
  input  logic [2:0]      rx,
  input  logic [2:0]      ry,
  output logic            pc_enable,
  output logic            pc_select,
  output logic [3:0]      bus_sel,
  output logic [NREG-1:0] reg_we,
  output logic            a_load,
  output logic            g_load,
  output logic            alu_sub,
  output logic            busy,
  output logic            halted,
  output logic            final_cycle
);

  logic [NREG-1:0] rx_onehot;

  // Register indices beyond NREG select nothing rather than alias.
  always_comb begin
    rx_onehot = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(rx) == i) rx_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    pc_enable   = 1'b0;
    pc_select   = 1'b0;
    bus_sel     = BUS_NONE;
    reg_we      = '0;
    a_load      = 1'b0;
    g_load      = 1'b0;
    alu_sub     = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    final_cycle = 1'b0;
    unique case (state)
      StIdle: ;
      StFetch: begin
        busy      = 1'b1;
        pc_enable = 1'b1;
      end
      StEx1: begin
        busy        = 1'b1;
        final_cycle = 1'b1;
        case (op)
          OP_MV: begin
            bus_sel = bus_reg(ry);
            reg_we  = rx_onehot;
          end
          OP_MVI: begin
            // Immediate lives in the word after the opcode; step PC past it.
            bus_sel   = BUS_MEM;
            reg_we    = rx_onehot;
            pc_enable = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_sel     = bus_reg(rx);
            a_load      = 1'b1;
            final_cycle = 1'b0;
          end
          OP_JMP: begin
            bus_sel   = bus_reg(rx);
            pc_enable = 1'b1;
            pc_select = 1'b1;
          end
          default: ;
        endcase
      end
      StEx2: begin
        busy    = 1'b1;
        bus_sel = bus_reg(ry);
        g_load  = 1'b1;
        alu_sub = (op == OP_SUB);
      end
      StEx3: begin
        busy        = 1'b1;
        bus_sel     = BUS_G;
        reg_we      = rx_onehot;
        final_cycle = 1'b1;
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction register plus fetch/execute FSM for the 16-bit CPU.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset (state -> IDLE, IR -> 0)
//   cpu : cpu_sequencer_if.master -- run/mem_data in, datapath strobes and status out
// Outputs are decoded from the registered state and IR only, so they are glitch-free
// with respect to run and mem_data.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned NREG = 8,
  parameter int unsigned W    = 16
) (
  input logic              clk,
  input logic              rst,
  cpu_sequencer_if.master  cpu
);

  seq_state_e   state_q, state_d;
  logic [W-1:0] ir_q;
  logic         final_cycle;

  logic [3:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       unused_ir_bits;

  assign op = ir_q[15:12];
  assign rx = ir_q[11:9];
  assign ry = ir_q[8:6];
  assign unused_ir_bits = ^ir_q[5:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch) ir_q <= cpu.mem_data;
    end
  end

  // run is only consulted in IDLE and on an instruction's final cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cpu.run) state_d = StFetch;
      StFetch: state_d = StEx1;
      StEx1: begin
        if (op == OP_HALT)  state_d = StHalt;
        else if (final_cycle) state_d = cpu.run ? StFetch : StIdle;
        else                state_d = StEx2;
      end
      StEx2:   state_d = StEx3;
      StEx3:   state_d = cpu.run ? StFetch : StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  cpu_ir_decode #(
    .NREG(NREG)
  ) u_decode (
    .state      (state_q),
    .op         (op),
    .rx         (rx),
    .ry         (ry),
    .pc_enable  (cpu.pc_enable),
    .pc_select  (cpu.pc_select),
    .bus_sel    (cpu.bus_sel),
    .reg_we     (cpu.reg_we),
    .a_load     (cpu.a_load),
    .g_load     (cpu.g_load),
    .alu_sub    (cpu.alu_sub),
    .busy       (cpu.busy),
    .halted     (cpu.halted),
    .final_cycle(final_cycle)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed program run through a small behavioural datapath.
// Stimulus pushes the hand-derived per-cycle output set; a negedge monitor pops
// and compares, so every cycle after the first reset edge is checked.
module tb_cpu_sequencer;

  typedef struct packed {
    logic       pe;
    logic       ps;
    logic [3:0] bs;
    logic [7:0] we;
    logic       al;
    logic       gl;
    logic       sb;
    logic       by;
    logic       hl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cpu_sequencer_if #(.NREG(8), .W(16)) sif ();

  cpu_sequencer #(.NREG(8), .W(16)) dut (
    .clk(clk),
    .rst(rst),
    .cpu(sif.master)
  );

  always #5 clk = ~clk;

  // Behavioural datapath and program memory.
  logic [15:0] mem [16];
  logic [15:0] regs [8];
  logic [15:0] pc, a_q, g_q, bus;

  assign sif.mem_data = (pc < 16'd16) ? mem[pc[3:0]] : 16'h0000;

  always_comb begin
    bus = 16'h0000;
    if (sif.bus_sel < 4'd8)       bus = regs[sif.bus_sel[2:0]];
    else if (sif.bus_sel == 4'd8) bus = g_q;
    else if (sif.bus_sel == 4'd9) bus = sif.mem_data;
  end

  always @(posedge clk) begin
    if (!rst) begin
      pc  <= 16'h0000;
      a_q <= 16'h0000;
      g_q <= 16'h0000;
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else begin
      if (sif.pc_enable) pc <= sif.pc_select ? bus : pc + 16'd1;
      for (int i = 0; i < 8; i++) if (sif.reg_we[i]) regs[i] <= bus;
      if (sif.a_load) a_q <= bus;
      if (sif.g_load) g_q <= sif.alu_sub ? a_q - bus : a_q + bus;
    end
  end

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_out = 0;
  exp_t exp_q [$];

  function automatic exp_t mk(logic pe, logic ps, logic [3:0] bs, logic [7:0] we,
                              logic al, logic gl, logic sb, logic by, logic hl);
    exp_t e;
    e = '{pe: pe, ps: ps, bs: bs, we: we, al: al, gl: gl, sb: sb, by: by, hl: hl};
    return e;
  endfunction

  // Monitor: one comparison per checked cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      g = '{pe: sif.pc_enable, ps: sif.pc_select, bs: sif.bus_sel, we: sif.reg_we,
            al: sif.a_load, gl: sif.g_load, sb: sif.alu_sub, by: sif.busy, hl: sif.halted};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL out[%0d]: got pe=%b ps=%b bs=%0d we=%h al=%b gl=%b sub=%b busy=%b halt=%b; want pe=%b ps=%b bs=%0d we=%h al=%b gl=%b sub=%b busy=%b halt=%b",
                 n_out, g.pe, g.ps, g.bs, g.we, g.al, g.gl, g.sb, g.by, g.hl,
                 e.pe, e.ps, e.bs, e.we, e.al, e.gl, e.sb, e.by, e.hl);
      end
      n_out++;
    end
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Queue this cycle's expected outputs, drive inputs, advance one clock.
  task automatic cyc(input logic rst_v, input logic run_v, input exp_t e);
    exp_q.push_back(e);
    rst = rst_v;
    sif.run = run_v;
    @(posedge clk);
    #1;
  endtask

  exp_t e_idle, e_fetch, e_halt, e_busy;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    e_idle  = mk(0, 0, 4'd15, 8'h00, 0, 0, 0, 0, 0);
    e_fetch = mk(1, 0, 4'd15, 8'h00, 0, 0, 0, 1, 0);
    e_halt  = mk(0, 0, 4'd15, 8'h00, 0, 0, 0, 0, 1);
    e_busy  = mk(0, 0, 4'd15, 8'h00, 0, 0, 0, 1, 0);

    mem[0]  = 16'h1400; // MVI R2,#1234
    mem[1]  = 16'h1234;
    mem[2]  = 16'h1200; // MVI R1,#5
    mem[3]  = 16'h0005;
    mem[4]  = 16'h1600; // MVI R3,#3
    mem[5]  = 16'h0003;
    mem[6]  = 16'h22C0; // ADD R1,R3
    mem[7]  = 16'h32C0; // SUB R1,R3
    mem[8]  = 16'h0840; // MV  R4,R1
    mem[9]  = 16'h1A00; // MVI R5,#C
    mem[10] = 16'h000C;
    mem[11] = 16'h4A00; // JMP R5
    mem[12] = 16'h7000; // NOP
    mem[13] = 16'h2880; // ADD R4,R2 (run dropped in EX2)
    mem[14] = 16'h5000; // HALT
    mem[15] = 16'h0000;

    rst = 1'b0;
    sif.run = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, e_idle);                                  // held in reset
    cyc(1, 1, e_idle);                                  // released, IDLE samples run

    // MVI R2,#1234
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(1, 0, 4'd9, 8'h04, 0, 0, 0, 1, 0));
    chk16("mvi_pc", pc, 16'd2);
    chk16("mvi_r2", regs[2], 16'h1234);

    // MVI R1,#5 ; MVI R3,#3
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(1, 0, 4'd9, 8'h02, 0, 0, 0, 1, 0));
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(1, 0, 4'd9, 8'h08, 0, 0, 0, 1, 0));
    chk16("mvi_r3", regs[3], 16'h0003);

    // ADD R1,R3
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(0, 0, 4'd1, 8'h00, 1, 0, 0, 1, 0));
    cyc(1, 1, mk(0, 0, 4'd3, 8'h00, 0, 1, 0, 1, 0));
    cyc(1, 1, mk(0, 0, 4'd8, 8'h02, 0, 0, 0, 1, 0));
    chk16("add_r1", regs[1], 16'h0008);

    // SUB R1,R3
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(0, 0, 4'd1, 8'h00, 1, 0, 0, 1, 0));
    cyc(1, 1, mk(0, 0, 4'd3, 8'h00, 0, 1, 1, 1, 0));
    cyc(1, 1, mk(0, 0, 4'd8, 8'h02, 0, 0, 0, 1, 0));
    chk16("sub_r1", regs[1], 16'h0005);

    // MV R4,R1
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(0, 0, 4'd1, 8'h10, 0, 0, 0, 1, 0));
    chk16("mv_r4", regs[4], 16'h0005);

    // MVI R5,#C ; JMP R5
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(1, 0, 4'd9, 8'h20, 0, 0, 0, 1, 0));
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(1, 1, 4'd5, 8'h00, 0, 0, 0, 1, 0));
    chk16("jmp_pc", pc, 16'h000C);

    // NOP
    cyc(1, 1, e_fetch);
    cyc(1, 1, e_busy);
    chk16("nop_pc", pc, 16'h000D);

    // ADD R4,R2 with run dropped in EX2: EX3 still writes, then IDLE
    cyc(1, 1, e_fetch);
    cyc(1, 1, mk(0, 0, 4'd4, 8'h00, 1, 0, 0, 1, 0));
    cyc(1, 0, mk(0, 0, 4'd2, 8'h00, 0, 1, 0, 1, 0));
    cyc(1, 0, mk(0, 0, 4'd8, 8'h10, 0, 0, 0, 1, 0));
    chk16("add_r4", regs[4], 16'h1239);
    cyc(1, 0, e_idle);
    cyc(1, 1, e_idle);

    // HALT
    cyc(1, 1, e_fetch);
    cyc(1, 1, e_busy);
    for (int i = 0; i < 10; i++) cyc(1, 1'(i % 2), e_halt);
    chk16("halt_pc", pc, 16'h000F);

    // Reset out of HALT
    cyc(0, 0, e_halt);
    cyc(1, 0, e_idle);
    cyc(1, 0, e_idle);

    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
